// File: rtl/ctrl_74hc165.sv
// Periodic reader for a daisy-chained 74HC165 chain: load, shift WIDTH bits in, strobe o_valid.
// Optional HC165_DEBOUNCE_EN: o_data only accepts a frame that matches the previous raw frame.
module ctrl_74hc165 #(
  parameter int WIDTH      = 16,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_q7,
  output logic             o_pl,
  output logic             o_cp,
  output logic             o_ce_n,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  localparam int CNT_LIM = (GAP_CYCLES > CLK_DIV) ? GAP_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_LIM);
  localparam int BIT_W   = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_GAP, S_LOAD, S_SHIFT} state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [BIT_W-1:0] r_bit, w_bit_nxt;
  logic             r_hi, w_hi_nxt;
  logic             w_capture, w_done;
  logic             r_q7_s1, r_q7_s2;
  logic [WIDTH-1:0] r_raw;
  logic [BIT_W-1:0] w_idx;
`ifdef HC165_DEBOUNCE_EN
  logic [WIDTH-1:0] r_prev;
`endif

  assign w_idx = BIT_LAST - r_bit;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_hi_nxt    = r_hi;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (r_cnt == DIV_LAST) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_bit_nxt   = '0;
          w_hi_nxt    = 1'b0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == DIV_LAST) begin
          w_cnt_nxt = '0;
          if (!r_hi) begin
            // Sample at the end of the low phase, just before the CP rising edge.
            w_capture = 1'b1;
            w_hi_nxt  = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_nxt = S_GAP;
            w_hi_nxt    = 1'b0;
            w_done      = 1'b1;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
            w_hi_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_GAP;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_hi    <= 1'b0;
      r_q7_s1 <= 1'b0;
      r_q7_s2 <= 1'b0;
      r_raw   <= '0;
      o_pl    <= 1'b1;
      o_cp    <= 1'b0;
      o_ce_n  <= 1'b1;
      o_data  <= '0;
      o_valid <= 1'b0;
`ifdef HC165_DEBOUNCE_EN
      r_prev  <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_hi    <= w_hi_nxt;
      r_q7_s1 <= i_q7;
      r_q7_s2 <= r_q7_s1;
      o_pl    <= (w_state_nxt != S_LOAD);
      o_ce_n  <= (w_state_nxt != S_SHIFT);
      o_cp    <= (w_state_nxt == S_SHIFT) && w_hi_nxt;
      o_valid <= w_done;
      if (w_capture) r_raw[w_idx] <= r_q7_s2;
      if (w_done) begin
`ifdef HC165_DEBOUNCE_EN
        r_prev <= r_raw;
        if (r_raw == r_prev) o_data <= r_raw;
`else
        o_data <= r_raw;
`endif
      end
    end
  end

endmodule
